icb_bank_slave: RTL

Parametrised ICB slave front-end for the accelerator. It decodes a small control/status register file and a word-addressed memory window, and routes window accesses to one of NUM_BANKS external SRAM banks selected by a MODE register. It generalises the fixed-width, write-only loader path to configurable data width, bank count and depth. It adds read-back, byte masks, error responses and a sticky done/busy status. It sits between the ICB bus and the accelerator's ifmap/weight/LUT buffers.

---
 rtl/icb_bank_slave_if.sv | 26 ++
 rtl/icb_bank_slave.sv | 113 +++++++++++
 2 files changed

// File: rtl/icb_bank_slave_if.sv
// ICB command/response channel bundle shared by the bank slave and its master.
// The master drives commands and response-ready; the slave drives command-ready and responses.
interface icb_bank_slave_if #(
    parameter int DW = 32
);
    logic            icb_cmd_valid;
    logic            icb_cmd_ready;
    logic            icb_cmd_read;
    logic [31:0]     icb_cmd_addr;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready;
    logic [DW-1:0]   icb_rsp_rdata;
    logic            icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/icb_bank_slave.sv
// ICB slave: CTRL/MODE/STATUS registers plus a word window routed to one of NUM_BANKS SRAMs.
// Latency: register/write response 1 cycle after accept, window read 2 cycles.
// Backpressure: one command in flight; cmd_ready drops until the response handshake completes.
module icb_bank_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
    parameter int          DW        = 32,
    parameter int          NUM_BANKS = 4,
    parameter int          DEPTH     = 4096,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    icb_bank_slave_if.slave icb,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_bank,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata,
    output logic            ctrl_start,
    input  logic            acc_done
);
    localparam int          BW        = DW / 8;
    localparam int          BSH       = (BW > 1) ? $clog2(BW) : 0;
    localparam logic [31:0] WIN_BASE  = 32'h0000_1000;
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * BW);
    localparam logic [4:0]  NB        = 5'(NUM_BANKS);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

    state_t        state_q;
    logic [3:0]    mode_q;
    logic          done_q, busy_q, start_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;

    logic [31:0]   offset, win_off;
    logic          hit_ctrl, hit_mode, hit_stat, hit_win, bank_ok;
    logic          accept, cmd_err, start_hit, stat_rd, rd_issue;
    logic [DW-1:0] rsp_rdata_d;

    always_comb begin
        offset      = icb.icb_cmd_addr - BASE_ADDR;
        win_off     = offset - WIN_BASE;
        hit_ctrl    = (offset == 32'h0);
        hit_mode    = (offset == 32'h4);
        hit_stat    = (offset == 32'h8);
        hit_win     = (offset >= WIN_BASE) && (win_off < WIN_BYTES);
        bank_ok     = ({1'b0, mode_q} < NB);
        accept      = icb.icb_cmd_valid && (state_q == IDLE);
        cmd_err     = !(hit_ctrl || hit_mode || hit_stat || hit_win)
                    || (hit_stat && !icb.icb_cmd_read)
                    || (hit_win && !bank_ok);
        start_hit   = accept && hit_ctrl && !icb.icb_cmd_read
                    && icb.icb_cmd_wmask[0] && icb.icb_cmd_wdata[0];
        stat_rd     = accept && hit_stat && icb.icb_cmd_read;
        mem_en      = accept && hit_win && bank_ok;
        rd_issue    = mem_en && icb.icb_cmd_read;
        mem_we      = !icb.icb_cmd_read;
        mem_bank    = mode_q;
        mem_addr    = win_off[BSH +: AW];
        mem_wdata   = icb.icb_cmd_wdata;
        mem_wmask   = icb.icb_cmd_wmask;
        // Register read data; STATUS returns the value before this access clears DONE.
        rsp_rdata_d = '0;
        if (icb.icb_cmd_read && hit_mode) rsp_rdata_d[3:0] = mode_q;
        if (icb.icb_cmd_read && hit_stat) rsp_rdata_d[1:0] = {busy_q, done_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            start_q <= start_hit;
            // A completion landing on the same cycle as a clear must leave DONE set.
            if (acc_done)                    done_q <= 1'b1;
            else if (start_hit || stat_rd)   done_q <= 1'b0;
            if (start_hit)                   busy_q <= 1'b1;
            else if (acc_done)               busy_q <= 1'b0;
            if (accept && hit_mode && !icb.icb_cmd_read && icb.icb_cmd_wmask[0])
                mode_q <= icb.icb_cmd_wdata[3:0];
            unique case (state_q)
                IDLE: if (accept) begin
                    rsp_err_q   <= cmd_err;
                    rsp_rdata_q <= rsp_rdata_d;
                    state_q     <= rd_issue ? RD_WAIT : RSP;
                end
                RD_WAIT: begin
                    rsp_rdata_q <= mem_rdata;
                    state_q     <= RSP;
                end
                RSP: if (icb.icb_rsp_ready) begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign icb.icb_cmd_ready = (state_q == IDLE);
    assign icb.icb_rsp_valid = (state_q == RSP);
    assign icb.icb_rsp_rdata = rsp_rdata_q;
    assign icb.icb_rsp_err   = rsp_err_q;
    assign ctrl_start        = start_q;
endmodule
